// File: rtl/id_stage_fwd.sv
// Decode/operand-fetch stage: owns the architectural register file, resolves
// operands through an EX > MEM > WB forwarding network, inserts a bubble on a
// load-use hazard and hands a registered bundle to EX over valid/ready.
//
// Handshake: an instruction moves from IF into this stage on a clock edge where
// if_valid_i && if_ready_o && !flush_i. The bundle moves on to EX on an edge
// where id_valid_o && ex_ready_i. While id_valid_o && !ex_ready_i, every output
// holds its value. flush_i raises if_ready_o so that IF drops the instruction
// it is presenting.
module id_stage_fwd #(
  parameter int XLEN    = 32,
  parameter int NUM_REG = 32,
  parameter int CTRL_W  = 24,
  parameter int CNT_W   = 16,
  localparam int RA_W   = $clog2(NUM_REG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid_i,
  output logic              if_ready_o,
  input  logic [XLEN-1:0]   if_pc_i,
  input  logic [XLEN-1:0]   if_imm_i,
  input  logic [CTRL_W-1:0] if_ctrl_i,
  input  logic [RA_W-1:0]   if_rs1_i,
  input  logic [RA_W-1:0]   if_rs2_i,
  input  logic [RA_W-1:0]   if_rd_i,
  input  logic              if_use_rs1_i,
  input  logic              if_use_rs2_i,
  input  logic              flush_i,
  input  logic [RA_W-1:0]   ex_rd_i,
  input  logic              ex_we_i,
  input  logic              ex_is_load_i,
  input  logic [XLEN-1:0]   ex_data_i,
  input  logic [RA_W-1:0]   mem_rd_i,
  input  logic              mem_we_i,
  input  logic [XLEN-1:0]   mem_data_i,
  input  logic [RA_W-1:0]   wb_rd_i,
  input  logic              wb_we_i,
  input  logic [XLEN-1:0]   wb_data_i,
  output logic              id_valid_o,
  input  logic              ex_ready_i,
  output logic [XLEN-1:0]   id_pc_o,
  output logic [XLEN-1:0]   id_imm_o,
  output logic [XLEN-1:0]   id_rs1_data_o,
  output logic [XLEN-1:0]   id_rs2_data_o,
  output logic [CTRL_W-1:0] id_ctrl_o,
  output logic [RA_W-1:0]   id_rs1_o,
  output logic [RA_W-1:0]   id_rs2_o,
  output logic [RA_W-1:0]   id_rd_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  logic [XLEN-1:0]   rf_q [NUM_REG];
  logic [XLEN-1:0]   rf_d [NUM_REG];

  logic              id_valid_q, id_valid_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   imm_q, imm_d;
  logic [XLEN-1:0]   rs1_data_q, rs1_data_d;
  logic [XLEN-1:0]   rs2_data_q, rs2_data_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [RA_W-1:0]   rs1_q, rs1_d;
  logic [RA_W-1:0]   rs2_q, rs2_d;
  logic [RA_W-1:0]   rd_q, rd_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic [XLEN-1:0]   rs1_fwd;
  logic [XLEN-1:0]   rs2_fwd;
  logic              hazard;
  logic              load_en;

  // Operand source selection for one read port. A load in EX has no data
  // yet, so it is skipped here; the hazard logic stalls any real consumer.
  // The WB match doubles as register-file write-through.
  function automatic logic [XLEN-1:0] fwd_sel(input logic [RA_W-1:0] addr,
                                              input logic [XLEN-1:0] rf_val);
    logic [XLEN-1:0] res;
    res = rf_val;
    if (addr == '0)                                          res = '0;
    else if (ex_we_i && !ex_is_load_i && ex_rd_i == addr)    res = ex_data_i;
    else if (mem_we_i && mem_rd_i == addr)                   res = mem_data_i;
    else if (wb_we_i && wb_rd_i == addr)                     res = wb_data_i;
    return res;
  endfunction

  // Forwarded operand values for the instruction presented by IF.
  always_comb begin
    rs1_fwd = fwd_sel(if_rs1_i, rf_q[if_rs1_i]);
    rs2_fwd = fwd_sel(if_rs2_i, rf_q[if_rs2_i]);
  end

  assign hazard = if_valid_i && ex_we_i && ex_is_load_i && (ex_rd_i != '0) &&
                  ((if_use_rs1_i && (if_rs1_i == ex_rd_i)) ||
                   (if_use_rs2_i && (if_rs2_i == ex_rd_i)));
  assign load_en    = ex_ready_i || !id_valid_q;
  assign if_ready_o = flush_i || (load_en && !hazard);

  // Register file next state: WB writes land here; x0 is never written.
  always_comb begin
    for (int i = 0; i < NUM_REG; i++) rf_d[i] = rf_q[i];
    if (wb_we_i && (wb_rd_i != '0)) rf_d[wb_rd_i] = wb_data_i;
  end

  // Register file storage, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REG; i++) rf_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REG; i++) rf_q[i] <= rf_d[i];
    end
  end

  // Output bundle next state: flush, then hold, then bubble, then load.
  always_comb begin
    id_valid_d  = id_valid_q;
    pc_d        = pc_q;
    imm_d       = imm_q;
    rs1_data_d  = rs1_data_q;
    rs2_data_d  = rs2_data_q;
    ctrl_d      = ctrl_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rd_d        = rd_q;
    stall_cnt_d = stall_cnt_q;
    if (flush_i) begin
      id_valid_d = 1'b0;
      ctrl_d     = '0;
    end else if (!load_en) begin
      id_valid_d = id_valid_q;
    end else if (hazard) begin
      id_valid_d = 1'b0;
      ctrl_d     = '0;
      if (stall_cnt_q != '1)
        stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      id_valid_d = if_valid_i;
      if (if_valid_i) begin
        pc_d       = if_pc_i;
        imm_d      = if_imm_i;
        rs1_data_d = rs1_fwd;
        rs2_data_d = rs2_fwd;
        ctrl_d     = if_ctrl_i;
        rs1_d      = if_rs1_i;
        rs2_d      = if_rs2_i;
        rd_d       = if_rd_i;
      end else begin
        ctrl_d     = '0;
      end
    end
  end

  // Output bundle and stall counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_valid_q  <= 1'b0;
      pc_q        <= '0;
      imm_q       <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      ctrl_q      <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      id_valid_q  <= id_valid_d;
      pc_q        <= pc_d;
      imm_q       <= imm_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      ctrl_q      <= ctrl_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign id_valid_o    = id_valid_q;
  assign id_pc_o       = pc_q;
  assign id_imm_o      = imm_q;
  assign id_rs1_data_o = rs1_data_q;
  assign id_rs2_data_o = rs2_data_q;
  assign id_ctrl_o     = ctrl_q;
  assign id_rs1_o      = rs1_q;
  assign id_rs2_o      = rs2_q;
  assign id_rd_o       = rd_q;
  assign stall_cnt_o   = stall_cnt_q;

endmodule

// File: tb/tb_id_stage_fwd.sv
// Bench for id_stage_fwd: forwarding vector table, then hand-written
// load-use, saturation, backpressure, flush and async-reset sequences.
module tb_id_stage_fwd;
  localparam int XLEN    = 32;
  localparam int NUM_REG = 32;
  localparam int CTRL_W  = 24;
  localparam int CNT_W   = 4;
  localparam int RA_W    = 5;
  localparam int W       = 4 * XLEN + CTRL_W;

  logic              clk, rst;
  logic              if_valid_i, if_ready_o;
  logic [XLEN-1:0]   if_pc_i, if_imm_i;
  logic [CTRL_W-1:0] if_ctrl_i;
  logic [RA_W-1:0]   if_rs1_i, if_rs2_i, if_rd_i;
  logic              if_use_rs1_i, if_use_rs2_i, flush_i;
  logic [RA_W-1:0]   ex_rd_i, mem_rd_i, wb_rd_i;
  logic              ex_we_i, ex_is_load_i, mem_we_i, wb_we_i;
  logic [XLEN-1:0]   ex_data_i, mem_data_i, wb_data_i;
  logic              id_valid_o, ex_ready_i;
  logic [XLEN-1:0]   id_pc_o, id_imm_o, id_rs1_data_o, id_rs2_data_o;
  logic [CTRL_W-1:0] id_ctrl_o;
  logic [RA_W-1:0]   id_rs1_o, id_rs2_o, id_rd_o;
  logic [CNT_W-1:0]  stall_cnt_o;

  id_stage_fwd #(.XLEN(XLEN), .NUM_REG(NUM_REG), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .if_valid_i(if_valid_i), .if_ready_o(if_ready_o),
    .if_pc_i(if_pc_i), .if_imm_i(if_imm_i), .if_ctrl_i(if_ctrl_i),
    .if_rs1_i(if_rs1_i), .if_rs2_i(if_rs2_i), .if_rd_i(if_rd_i),
    .if_use_rs1_i(if_use_rs1_i), .if_use_rs2_i(if_use_rs2_i),
    .flush_i(flush_i),
    .ex_rd_i(ex_rd_i), .ex_we_i(ex_we_i), .ex_is_load_i(ex_is_load_i), .ex_data_i(ex_data_i),
    .mem_rd_i(mem_rd_i), .mem_we_i(mem_we_i), .mem_data_i(mem_data_i),
    .wb_rd_i(wb_rd_i), .wb_we_i(wb_we_i), .wb_data_i(wb_data_i),
    .id_valid_o(id_valid_o), .ex_ready_i(ex_ready_i),
    .id_pc_o(id_pc_o), .id_imm_o(id_imm_o),
    .id_rs1_data_o(id_rs1_data_o), .id_rs2_data_o(id_rs2_data_o),
    .id_ctrl_o(id_ctrl_o), .id_rs1_o(id_rs1_o), .id_rs2_o(id_rs2_o), .id_rd_o(id_rd_o),
    .stall_cnt_o(stall_cnt_o)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_exp;

  typedef struct {
    logic ex_we; logic ex_ld; logic [4:0] ex_rd; logic [31:0] ex_d;
    logic mem_we; logic [4:0] mem_rd; logic [31:0] mem_d;
    logic wb_we; logic [4:0] wb_rd; logic [31:0] wb_d;
    logic [4:0] rs1; logic [4:0] rs2; logic u1; logic u2;
    logic [31:0] e1; logic [31:0] e2;
  } vec_t;
  vec_t vt[11];

  task automatic check(input string n, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  function automatic logic [W-1:0] bundle(input logic [31:0] pc, input logic [31:0] d1,
                                          input logic [31:0] d2, input logic [23:0] ctrl);
    return {pc, pc ^ 32'h5A5A, d1, d2, ctrl};
  endfunction

  // Driver tasks
  task automatic set_instr(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic u1, input logic u2,
                           input logic [23:0] ctrl);
    if_valid_i = v; if_pc_i = pc; if_imm_i = pc ^ 32'h5A5A; if_ctrl_i = ctrl;
    if_rs1_i = rs1; if_rs2_i = rs2; if_rd_i = 5'd1;
    if_use_rs1_i = u1; if_use_rs2_i = u2;
  endtask

  task automatic clear_prod();
    ex_we_i = 0; ex_is_load_i = 0; ex_rd_i = 0; ex_data_i = 0;
    mem_we_i = 0; mem_rd_i = 0; mem_data_i = 0;
    wb_we_i = 0; wb_rd_i = 0; wb_data_i = 0;
  endtask

  // One cycle: inputs already driven at the negedge. Checks if_ready_o before
  // the edge, pushes the expected bundle on acceptance, and compares after it.
  task automatic step(input logic exp_ready, input logic exp_accept, input logic exp_valid,
                      input logic [W-1:0] exp_b, input string n);
    #1;
    check({n, "_ready"}, if_ready_o, exp_ready);
    if (exp_accept) exp_q.push_back(exp_b);
    @(posedge clk);
    #1;
    check({n, "_valid"}, id_valid_o, exp_valid);
    if (exp_valid) begin
      if (exp_accept) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL %s_sb: got empty queue expected an entry", n);
        end else begin
          last_exp = exp_q.pop_front();
        end
      end
      check({n, "_bundle"}, {id_pc_o, id_imm_o, id_rs1_data_o, id_rs2_data_o, id_ctrl_o}, last_exp);
    end
    @(negedge clk);
  endtask

  initial begin
    // EX/MEM/WB setup, rs1, rs2, uses, expected rs1/rs2 data. File starts x5=11 x6=66 x9=99.
    vt[0]  = '{0,0,0,0,           0,0,0,            0,0,0,            5,6,1,1, 32'h11,  32'h66};
    vt[1]  = '{1,0,5,32'h44,      1,5,32'h33,       1,5,32'h22,       5,9,1,1, 32'h44,  32'h99};
    vt[2]  = '{0,0,0,0,           1,5,32'h33,       1,5,32'h22,       5,6,1,1, 32'h33,  32'h66};
    vt[3]  = '{0,0,0,0,           0,0,0,            1,5,32'h22,       5,5,1,1, 32'h22,  32'h22};
    vt[4]  = '{0,0,0,0,           0,0,0,            0,0,0,            5,6,1,1, 32'h22,  32'h66};
    vt[5]  = '{1,0,0,32'h1234,    0,0,0,            1,0,32'hFFFF,     0,0,1,1, 32'h0,   32'h0};
    vt[6]  = '{1,1,7,32'h7777,    0,0,0,            0,0,0,            6,7,1,0, 32'h66,  32'h0};
    vt[7]  = '{1,1,9,32'h9999,    0,0,0,            0,0,0,            9,5,0,1, 32'h99,  32'h22};
    vt[8]  = '{1,0,6,32'hCAFE,    1,6,32'hBEEF,     0,0,0,            6,6,1,1, 32'hCAFE,32'hCAFE};
    vt[9]  = '{0,0,0,0,           1,9,32'h1357,     1,9,32'h2468,     9,5,1,1, 32'h1357,32'h22};
    vt[10] = '{0,0,0,0,           0,0,0,            0,0,0,            9,6,1,1, 32'h2468,32'h66};

    rst = 1; flush_i = 0; ex_ready_i = 1; last_exp = '0;
    clear_prod();
    set_instr(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    check("rst_valid", id_valid_o, 0);
    check("rst_stall", stall_cnt_o, 0);
    check("rst_pc", id_pc_o, 0);
    check("rst_ctrl", id_ctrl_o, 0);
    rst = 0;

    // Preload the register file through WB.
    wb_we_i = 1; wb_rd_i = 5; wb_data_i = 32'h11; step(1, 0, 0, '0, "pre5");
    wb_rd_i = 6; wb_data_i = 32'h66;              step(1, 0, 0, '0, "pre6");
    wb_rd_i = 9; wb_data_i = 32'h99;              step(1, 0, 0, '0, "pre9");
    clear_prod();

    // Forwarding vector table.
    for (int i = 0; i < 11; i++) begin
      ex_we_i = vt[i].ex_we; ex_is_load_i = vt[i].ex_ld; ex_rd_i = vt[i].ex_rd; ex_data_i = vt[i].ex_d;
      mem_we_i = vt[i].mem_we; mem_rd_i = vt[i].mem_rd; mem_data_i = vt[i].mem_d;
      wb_we_i = vt[i].wb_we; wb_rd_i = vt[i].wb_rd; wb_data_i = vt[i].wb_d;
      set_instr(1, 32'h100 + 32'(4 * i), vt[i].rs1, vt[i].rs2, vt[i].u1, vt[i].u2, 24'h100 + 24'(i));
      step(1, 1, 1, bundle(32'h100 + 32'(4 * i), vt[i].e1, vt[i].e2, 24'h100 + 24'(i)),
           $sformatf("vec%0d", i));
    end
    clear_prod();
    check("stall_after_vec", stall_cnt_o, 0);

    // Load-use: one bubble, then the load data arrives from MEM.
    ex_we_i = 1; ex_is_load_i = 1; ex_rd_i = 7; ex_data_i = 32'h5555;
    set_instr(1, 32'h200, 0, 7, 0, 1, 24'h200);
    step(0, 0, 0, '0, "lu_bubble");
    check("lu_ctrl_zero", id_ctrl_o, 0);
    check("lu_stall1", stall_cnt_o, 1);
    clear_prod();
    mem_we_i = 1; mem_rd_i = 7; mem_data_i = 32'hABCD;
    step(1, 1, 1, bundle(32'h200, 0, 32'hABCD, 24'h200), "lu_accept");
    check("lu_stall_hold", stall_cnt_o, 1);
    clear_prod();

    // Stall counter saturation (17 hazard cycles on a 4-bit counter).
    ex_we_i = 1; ex_is_load_i = 1; ex_rd_i = 7;
    set_instr(1, 32'h240, 7, 0, 1, 0, 24'h240);
    step(0, 0, 0, '0, "sat_first");
    check("sat_stall2", stall_cnt_o, 2);
    for (int i = 0; i < 15; i++) step(0, 0, 0, '0, "sat_loop");
    check("sat_stall15", stall_cnt_o, 15);
    clear_prod();

    // Backpressure: three held cycles, producer inputs wiggle meanwhile.
    set_instr(1, 32'h300, 5, 6, 1, 1, 24'h300);
    step(1, 1, 1, bundle(32'h300, 32'h22, 32'h66, 24'h300), "bp_load");
    ex_ready_i = 0;
    mem_we_i = 1; mem_rd_i = 5; mem_data_i = 32'hDEAD;
    set_instr(1, 32'h304, 9, 0, 1, 0, 24'h304);
    for (int i = 0; i < 3; i++) step(0, 0, 1, '0, $sformatf("bp_hold%0d", i));
    clear_prod();
    ex_ready_i = 1;
    step(1, 1, 1, bundle(32'h304, 32'h2468, 0, 24'h304), "bp_release");

    // Flush during backpressure.
    set_instr(1, 32'h308, 6, 5, 1, 1, 24'h308);
    step(1, 1, 1, bundle(32'h308, 32'h66, 32'h22, 24'h308), "fl_load");
    ex_ready_i = 0; flush_i = 1;
    set_instr(1, 32'h30C, 5, 5, 1, 1, 24'h30C);
    step(1, 0, 0, '0, "fl_flush");
    check("fl_ctrl_zero", id_ctrl_o, 0);
    flush_i = 0; ex_ready_i = 1;
    set_instr(0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, '0, "fl_idle");

    // Asynchronous reset mid-stream.
    set_instr(1, 32'h310, 5, 6, 1, 1, 24'h310);
    step(1, 1, 1, bundle(32'h310, 32'h22, 32'h66, 24'h310), "ar_load");
    #2 rst = 1;
    #1;
    check("ar_valid", id_valid_o, 0);
    check("ar_stall", stall_cnt_o, 0);
    check("ar_ctrl", id_ctrl_o, 0);
    check("ar_pc", id_pc_o, 0);
    exp_q.delete();
    @(negedge clk);
    rst = 0;
    set_instr(1, 32'h400, 5, 9, 1, 1, 24'h400);
    step(1, 1, 1, bundle(32'h400, 0, 0, 24'h400), "ar_rf_cleared");

    check("sb_empty", W'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish before 100000");
    $fatal(1);
  end
endmodule
